mult_share_ctrl: RTL and testbench

- Shares one pipelined sign-magnitude 32x32->64 multiplier between NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle and tracks in-flight tags through the multiplier latency.
- Each result is held in a per-requester response slot until that requester accepts it.
- Sits between requester blocks and the multiplier's in1/in2/out datapath.

---
 rtl/mult_share_ctrl_pkg.sv | 25 ++
 rtl/mult_share_ctrl_rr_arbiter.sv | 31 +++
 rtl/mult_share_ctrl.sv | 94 +++++++++
 tb/tb_mult_share_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// Sign-magnitude operands: top bit is the sign, the rest is the magnitude.
package mult_pkg;

  localparam int W         = 32;
  localparam int PROD_W    = 2 * W;
  localparam int SIGN_IDX  = W - 1;
  localparam int PSIGN_IDX = PROD_W - 1;
  localparam int MAX_REQ   = 8;
  localparam int IDX_W     = $clog2(MAX_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // A zero magnitude always leaves with a positive sign.
  function automatic logic [PROD_W-1:0] sm_norm(input logic [PROD_W-1:0] p);
    logic [PROD_W-1:0] r;
    r = p;
    if (p[PSIGN_IDX-1:0] == '0) r[PSIGN_IDX] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Round-robin pick of the first eligible requester at or after ptr, wrapping; combinational.
// No state, no backpressure: gnt is all-zero when nothing is eligible.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && elig[j] && (j == (int'(ptr) + k) % N)) begin
          found   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one pipelined sign-magnitude multiplier among NUM_REQ requesters; results land MUL_LAT+1 cycles after grant.
// A full response slot keeps its requester pending, so regrant waits until rsp_ready drains the slot.
module mult_share_ctrl
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*W-1:0]   req_in1,
  input  logic [NUM_REQ*W-1:0]   req_in2,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [NUM_REQ*PROD_W-1:0] rsp_data,
  output logic [W-1:0]           mul_in1,
  output logic [W-1:0]           mul_in2,
  input  logic [PROD_W-1:0]      mul_out,
  output logic                   busy
);

  logic [NUM_REQ-1:0]             pending;
  logic [NUM_REQ-1:0]             elig;
  logic [NUM_REQ-1:0]             gnt;
  logic [IDX_W-1:0]               gnt_idx;
  logic [IDX_W-1:0]               ptr;
  logic [NUM_REQ-1:0][PROD_W-1:0] slot;
  tag_t                           tag_q [MUL_LAT+1];
  tag_t                           cap;
  logic                           any_grant;
  logic                           tags_busy;

  // Gating with rst keeps req_ready low for the whole reset window.
  assign elig      = req_valid & ~pending & {NUM_REQ{rst}};
  assign req_ready = gnt;
  assign any_grant = |gnt;
  assign cap       = tag_q[MUL_LAT];
  assign rsp_data  = slot;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .elig    (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      mul_in1 <= '0;
      mul_in2 <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0].valid <= any_grant;
      tag_q[0].idx   <= any_grant ? gnt_idx : '0;
      for (int k = 1; k <= MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
      if (any_grant) begin
        mul_in1 <= req_in1[int'(gnt_idx)*W +: W];
        mul_in2 <= req_in2[int'(gnt_idx)*W +: W];
        ptr     <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Capture and acceptance never target the same slot: pending blocks reissue until drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      rsp_valid <= '0;
      slot      <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap.valid && int'(cap.idx) == i) begin
          rsp_valid[i] <= 1'b1;
          slot[i]      <= sm_norm(mul_out);
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
        if (gnt[i]) pending[i] <= 1'b1;
        else if (rsp_valid[i] && rsp_ready[i]) pending[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) tags_busy = tags_busy | tag_q[k].valid;
  end

  assign busy = (|pending) | tags_busy;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a sign-magnitude multiplier model behind mul_in/mul_out.
module tb_mult_share_ctrl;

  localparam int NUM_REQ = 2;
  localparam int W       = 32;
  localparam int PW      = 64;
  localparam int MUL_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*W-1:0]    req_in1, req_in2;
  logic [NUM_REQ*PW-1:0]   rsp_data;
  logic [W-1:0]            mul_in1, mul_in2;
  logic [PW-1:0]           mul_out;
  logic                    busy;
  logic                    garbage;
  int                      total = 0;
  int                      bad   = 0;

  mult_share_ctrl #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_out   (mul_out),
    .busy      (busy)
  );

  function automatic logic [PW-1:0] sm_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-2:0] mag;
    mag = (PW-1)'(a[W-2:0]) * (PW-1)'(b[W-2:0]);
    return {a[W-1] ^ b[W-1], mag};
  endfunction

  logic [PW-1:0] mpipe [MUL_LAT];
  always_ff @(posedge clk) begin
    mpipe[0] <= sm_mul(mul_in1, mul_in2);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_out = garbage ? 64'hDEAD_BEEF_CAFE_F00D : mpipe[MUL_LAT-1];

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " req_ready"}, req_ready, 0);
    chk({nm, " rsp_valid"}, rsp_valid, 0);
    chk({nm, " rsp_data0"}, rsp_data[63:0], 0);
    chk({nm, " rsp_data1"}, rsp_data[127:64], 0);
    chk({nm, " mul_in1"}, mul_in1, 0);
    chk({nm, " mul_in2"}, mul_in2, 0);
    chk({nm, " busy"}, busy, 0);
  endtask

  // Issue one op, measure edges from handshake to rsp_valid, check data, accept.
  task automatic do_op(input string nm, input int r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [PW-1:0] exp);
    int n;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_in1[r*W +: W] = a;
    req_in2[r*W +: W] = b;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, " grant"}, req_ready[r], 1'b1);
    @(negedge clk);
    req_valid[r] = 1'b0;
    n = 0;
    while (!rsp_valid[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, MUL_LAT + 1);
    chk({nm, " data"}, rsp_data[r*PW +: PW], exp);
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
    chk({nm, " drained"}, rsp_valid[r], 1'b0);
  endtask

  typedef struct {
    int            r;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t       vecs [7];
  logic [1:0] fair_exp [12];
  logic [1:0] prev;

  initial begin
    vecs[0] = '{0, 32'h00000005, 32'h80000003, 64'h800000000000000F};
    vecs[1] = '{1, 32'h00000007, 32'h00000006, 64'h000000000000002A};
    vecs[2] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
    vecs[3] = '{1, 32'hFFFFFFFF, 32'h00000002, 64'h80000000FFFFFFFE};
    vecs[4] = '{0, 32'h80000005, 32'h00000000, 64'h0000000000000000};
    vecs[5] = '{1, 32'h00000000, 32'h80000009, 64'h0000000000000000};
    vecs[6] = '{1, 32'h80000010, 32'h80000010, 64'h0000000000000100};
    for (int k = 0; k < 12; k++) fair_exp[k] = (k % 4 == 0) ? 2'b01 : (k % 4 == 1) ? 2'b10 : 2'b00;

    rst = 1'b0; garbage = 1'b0;
    req_valid = '0; rsp_ready = '0; req_in1 = '0; req_in2 = '0;
    #1;
    chk_reset("init");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Reset while slot 1 is full and a tag for requester 0 is in flight.
    @(negedge clk);
    req_valid = 2'b10; req_in1[63:32] = 32'h3; req_in2[63:32] = 32'h4;
    #1 chk("rst pre grant1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst pre slot1", rsp_valid, 2'b10);
    req_valid = 2'b01; req_in1[31:0] = 32'h2; req_in2[31:0] = 32'h2;
    #1 chk("rst pre grant0", req_ready, 2'b01);
    @(negedge clk);
    chk("rst busy inflight", busy, 1'b1);
    rst = 1'b0; req_valid = 2'b11;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; garbage = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post rst no capture %0d", c), rsp_valid, 2'b00);
    end
    garbage = 1'b0;

    // Contention straight after reset: pointer is at requester 0.
    @(negedge clk);
    req_valid = 2'b11;
    req_in1 = {32'h80000004, 32'h00000008};
    req_in2 = {32'h80000003, 32'h00000002};
    #1 chk("contend first", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    #1 chk("contend second", req_ready, 2'b10);
    chk("contend mul_in1 a", mul_in1, 32'h00000008);
    @(negedge clk);
    req_valid = 2'b00;
    chk("contend mul_in1 b", mul_in1, 32'h80000004);
    chk("contend mul_in2 b", mul_in2, 32'h80000003);
    chk("contend rsp none", rsp_valid, 2'b00);
    @(negedge clk);
    chk("contend rsp0 valid", rsp_valid, 2'b01);
    chk("contend rsp0 data", rsp_data[63:0], 64'h0000000000000010);
    @(negedge clk);
    chk("contend rsp1 valid", rsp_valid, 2'b11);
    chk("contend rsp1 data", rsp_data[127:64], 64'h000000000000000C);
    rsp_ready = 2'b11;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("contend drained", rsp_valid, 2'b00);
    chk("contend idle", busy, 1'b0);

    // Backpressure on slot 0.
    @(negedge clk);
    req_valid[0] = 1'b1; req_in1[31:0] = 32'h3; req_in2[31:0] = 32'h3;
    #1 chk("bp grant", req_ready[0], 1'b1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp slot full", rsp_valid[0], 1'b1);
    chk("bp slot data", rsp_data[63:0], 64'h9);
    req_valid[0] = 1'b1; req_in1[31:0] = 32'h00000009; req_in2[31:0] = 32'h80000002;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp blocked %0d", c), req_ready[0], 1'b0);
      chk($sformatf("bp stable %0d", c), rsp_data[63:0], 64'h9);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    #1 chk("bp same-cycle no grant", req_ready[0], 1'b0);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    #1 chk("bp regrant", req_ready[0], 1'b1);
    chk("bp accepted", rsp_valid[0], 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp new valid", rsp_valid[0], 1'b1);
    chk("bp new data", rsp_data[63:0], 64'h8000000000000012);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;

    // Move the pointer back to requester 0 before the fairness run.
    do_op("pre fair", 1, 32'h5, 32'h5, 64'h19);

    @(negedge clk);
    req_in1 = {32'h80000004, 32'h00000002};
    req_in2 = {32'h00000005, 32'h00000003};
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    prev = 2'b00;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("fair grant %0d", k), req_ready, fair_exp[k]);
      if (prev == 2'b01) chk($sformatf("fair mul_in1 %0d", k), mul_in1, 32'h00000002);
      else if (prev == 2'b10) chk($sformatf("fair mul_in1 %0d", k), mul_in1, 32'h80000004);
      prev = fair_exp[k];
      @(negedge clk);
    end
    req_valid = 2'b00;
    #1;
    chk("fair busy tail", busy, 1'b1);
    chk("fair rsp tail", rsp_valid, 2'b10);
    chk("fair data0", rsp_data[63:0], 64'h0000000000000006);
    chk("fair data1", rsp_data[127:64], 64'h8000000000000014);
    @(negedge clk);
    chk("fair busy end", busy, 1'b0);
    chk("fair rsp end", rsp_valid, 2'b00);
    rsp_ready = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
